// File: rtl/wait_event_sched_if.sv
// Command, detector and response signals of the wait-event sequencer.
// master = command/response/detector-model side, slave = sequencer.
interface wait_event_sched_if #(
  parameter int TO_WIDTH = 32
);
  logic                i_cmd_valid;
  logic                o_cmd_ready;
  logic [31:0]         i_cmd_idx;
  logic                i_cmd_wtf;
  logic [TO_WIDTH-1:0] i_cmd_timeout;
  logic                i_abort;
  logic [31:0]         o_wait_en;
  logic                o_sel_wtr_wtf;
  logic [TO_WIDTH-1:0] o_max_timeout;
  logic                i_wait_done;
  logic                o_busy;
  logic                o_rsp_valid;
  logic                i_rsp_ready;
  logic [1:0]          o_rsp_status;
  logic [TO_WIDTH-1:0] o_rsp_cycles;

  modport master (
    output i_cmd_valid, i_cmd_idx, i_cmd_wtf, i_cmd_timeout, i_abort,
    output i_wait_done, i_rsp_ready,
    input  o_cmd_ready, o_wait_en, o_sel_wtr_wtf, o_max_timeout,
    input  o_busy, o_rsp_valid, o_rsp_status, o_rsp_cycles
  );

  modport slave (
    input  i_cmd_valid, i_cmd_idx, i_cmd_wtf, i_cmd_timeout, i_abort,
    input  i_wait_done, i_rsp_ready,
    output o_cmd_ready, o_wait_en, o_sel_wtr_wtf, o_max_timeout,
    output o_busy, o_rsp_valid, o_rsp_status, o_rsp_cycles
  );
endinterface

// File: rtl/wait_event_sched.sv
// Wait-event sequencer: queues wait commands, arms the edge detector one at a
// time, times each wait and returns a status/cycle-count response.
module wait_event_sched #(
  parameter int WAIT_SIZE  = 5,
  parameter int FIFO_DEPTH = 4,
  parameter int TO_WIDTH   = 32
) (
  input logic              clk,
  input logic              rst_n,
  wait_event_sched_if.slave bus
);
  localparam int PW = $clog2(FIFO_DEPTH);

  localparam logic [1:0] ST_DONE    = 2'b00;
  localparam logic [1:0] ST_TIMEOUT = 2'b01;
  localparam logic [1:0] ST_BAD_IDX = 2'b10;
  localparam logic [1:0] ST_ABORTED = 2'b11;

  typedef struct packed {
    logic [31:0]         idx;
    logic                wtf;
    logic [TO_WIDTH-1:0] timeout;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, ARM, WAIT, RESP} state_t;

  cmd_t                fifo_mem [FIFO_DEPTH];
  cmd_t                head;
  cmd_t                wr_cmd;
  logic [PW-1:0]       wr_ptr, rd_ptr;
  logic [PW:0]         count;
  logic                full, empty, push, pop, head_bad;
  state_t              state, state_d;
  logic [TO_WIDTH-1:0] cnt, cnt_inc;
  logic                load_rsp;
  logic [1:0]          rsp_status_d;
  logic [TO_WIDTH-1:0] rsp_cycles_d;

  assign full     = count == (PW+1)'(FIFO_DEPTH);
  assign empty    = count == '0;
  assign head     = fifo_mem[rd_ptr];
  // Unsigned compare also rejects negative int indices.
  assign head_bad = head.idx >= 32'(WAIT_SIZE);
  assign push     = bus.i_cmd_valid && !full && !bus.i_abort;
  assign pop      = (state == IDLE) && !empty && !bus.i_abort;
  assign cnt_inc  = (&cnt) ? cnt : cnt + 1'b1;
  assign wr_cmd   = '{idx: bus.i_cmd_idx, wtf: bus.i_cmd_wtf, timeout: bus.i_cmd_timeout};

  assign bus.o_cmd_ready = !full;
  assign bus.o_busy      = (state != IDLE) || !empty;
  assign bus.o_rsp_valid = state == RESP;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= wr_cmd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d      = state;
    load_rsp     = 1'b0;
    rsp_status_d = ST_DONE;
    rsp_cycles_d = '0;
    case (state)
      IDLE: if (pop) begin
        if (head_bad) begin
          state_d      = RESP;
          load_rsp     = 1'b1;
          rsp_status_d = ST_BAD_IDX;
        end else begin
          state_d = ARM;
        end
      end
      ARM: begin
        state_d = WAIT;
        if (bus.i_abort) begin
          state_d      = RESP;
          load_rsp     = 1'b1;
          rsp_status_d = ST_ABORTED;
          rsp_cycles_d = cnt;
        end
      end
      WAIT: begin
        if (bus.i_abort) begin
          state_d      = RESP;
          load_rsp     = 1'b1;
          rsp_status_d = ST_ABORTED;
          rsp_cycles_d = cnt;
        end else if (bus.i_wait_done) begin
          state_d      = RESP;
          load_rsp     = 1'b1;
          rsp_status_d = ST_DONE;
          rsp_cycles_d = cnt_inc;
        end else if ((|bus.o_max_timeout) && cnt_inc == bus.o_max_timeout) begin
          state_d      = RESP;
          load_rsp     = 1'b1;
          rsp_status_d = ST_TIMEOUT;
          rsp_cycles_d = bus.o_max_timeout;
        end
      end
      // Abort leaves a pending response untouched, handshake included.
      RESP: if (!bus.i_abort && bus.i_rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      count             <= '0;
      cnt               <= '0;
      bus.o_wait_en     <= '0;
      bus.o_sel_wtr_wtf <= 1'b0;
      bus.o_max_timeout <= '0;
      bus.o_rsp_status  <= ST_DONE;
      bus.o_rsp_cycles  <= '0;
    end else begin
      if (bus.i_abort) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        count <= count + (PW+1)'(push) - (PW+1)'(pop);
      end
      if (pop && !head_bad) begin
        bus.o_wait_en     <= head.idx;
        bus.o_sel_wtr_wtf <= head.wtf;
        bus.o_max_timeout <= head.timeout;
      end
      // Clear on pop so an abort during ARM reports zero cycles.
      if (pop || state == ARM) cnt <= '0;
      else if (state == WAIT)  cnt <= cnt_inc;
      if (load_rsp) begin
        bus.o_rsp_status <= rsp_status_d;
        bus.o_rsp_cycles <= rsp_cycles_d;
      end
    end
  end
endmodule

// File: tb/tb_wait_event_sched.sv
// Bench for wait_event_sched: vector table, directed corner sequences and
// random traffic against a timestamp-based reference model.
module tb_wait_event_sched;
  localparam int TO_W = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  wait_event_sched_if #(.TO_WIDTH(TO_W)) bus();

  wait_event_sched #(.WAIT_SIZE(5), .FIFO_DEPTH(4), .TO_WIDTH(TO_W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Reference model: a command list plus the edge number at which the active
  // command was popped; elapsed cycles are plain differences of edge numbers.
  typedef struct { int idx; bit wtf; int unsigned to; } mcmd_t;
  mcmd_t       m_q[$];
  mcmd_t       m_cur;
  bit          m_have, m_rsp, m_sel;
  int          m_e, m_k;
  int unsigned m_st, m_cy, m_en, m_to;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_have = 0; m_rsp = 0; m_e = 0; m_k = 0;
      m_st = 0; m_cy = 0; m_en = 0; m_sel = 0; m_to = 0;
    end else begin
      bit    ready, idle;
      mcmd_t c;
      m_e++;
      ready = m_q.size() < 4;
      idle  = !m_have && !m_rsp;
      if (bus.i_abort) begin
        m_q.delete();
        if (m_have) begin
          m_have = 0; m_rsp = 1; m_st = 3;
          m_cy = (m_e >= m_k + 2) ? m_e - m_k - 2 : 0;
        end
      end else begin
        if (idle && m_q.size() > 0) begin
          c = m_q.pop_front();
          if (c.idx < 0 || c.idx >= 5) begin
            m_rsp = 1; m_st = 2; m_cy = 0;
          end else begin
            m_have = 1; m_k = m_e; m_cur = c;
            m_en = c.idx; m_sel = c.wtf; m_to = c.to;
          end
        end else if (m_have && m_e >= m_k + 2) begin
          if (bus.i_wait_done) begin
            m_have = 0; m_rsp = 1; m_st = 0; m_cy = m_e - m_k - 1;
          end else if (m_cur.to != 0 && m_e - m_k - 1 == m_cur.to) begin
            m_have = 0; m_rsp = 1; m_st = 1; m_cy = m_cur.to;
          end
        end else if (m_rsp && bus.i_rsp_ready) begin
          m_rsp = 0;
        end
        if (bus.i_cmd_valid && ready) begin
          c.idx = int'(bus.i_cmd_idx); c.wtf = bus.i_cmd_wtf; c.to = bus.i_cmd_timeout;
          m_q.push_back(c);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      chk("m_ready", bus.o_cmd_ready, m_q.size() < 4);
      chk("m_busy", bus.o_busy, m_have || m_rsp || m_q.size() > 0);
      chk("m_rsp_valid", bus.o_rsp_valid, m_rsp);
      chk("m_wait_en", bus.o_wait_en, m_en);
      chk("m_sel", bus.o_sel_wtr_wtf, m_sel);
      chk("m_max_to", bus.o_max_timeout, m_to);
      if (m_rsp) begin
        chk("m_status", bus.o_rsp_status, m_st);
        chk("m_cycles", bus.o_rsp_cycles, m_cy);
      end
    end
  end

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic idle_in();
    bus.i_cmd_valid = 0; bus.i_abort = 0; bus.i_wait_done = 0; bus.i_rsp_ready = 0;
  endtask

  task automatic set_cmd(int idx, bit wtf, int unsigned to);
    bus.i_cmd_valid = 1; bus.i_cmd_idx = idx; bus.i_cmd_wtf = wtf; bus.i_cmd_timeout = to;
  endtask

  task automatic ack();
    bus.i_rsp_ready = 1; tick(1); bus.i_rsp_ready = 0;
  endtask

  task automatic get_rsp(string name, int st, int unsigned cy);
    int n = 0;
    while (!bus.o_rsp_valid && n < 20) begin tick(1); n++; end
    chk({name, "_seen"}, bus.o_rsp_valid, 1);
    chk({name, "_st"}, bus.o_rsp_status, st);
    chk({name, "_cy"}, bus.o_rsp_cycles, cy);
    ack();
  endtask

  task automatic chk_reset_vals(string p);
    chk({p, "_ready"}, bus.o_cmd_ready, 1);
    chk({p, "_wait_en"}, bus.o_wait_en, 0);
    chk({p, "_sel"}, bus.o_sel_wtr_wtf, 0);
    chk({p, "_max_to"}, bus.o_max_timeout, 0);
    chk({p, "_busy"}, bus.o_busy, 0);
    chk({p, "_rsp_valid"}, bus.o_rsp_valid, 0);
    chk({p, "_status"}, bus.o_rsp_status, 0);
    chk({p, "_cycles"}, bus.o_rsp_cycles, 0);
  endtask

  typedef struct {
    bit v; int idx; bit wtf; int unsigned to; bit rr;
    bit e_rdy; bit e_busy; bit e_rv; int e_st; int unsigned e_cy; int unsigned e_en; bit e_sel;
  } vec_t;
  vec_t tbl[9];

  initial begin
    // Row i drives the edge, columns after rr are the outputs after that edge.
    tbl[0] = '{1, 5, 0, 10, 0,  1, 1, 0, 0, 0, 0, 0};
    tbl[1] = '{0, 0, 0, 0,  0,  1, 1, 1, 2, 0, 0, 0};
    tbl[2] = '{0, 0, 0, 0,  1,  1, 0, 0, 0, 0, 0, 0};
    tbl[3] = '{1, 3, 1, 2,  0,  1, 1, 0, 0, 0, 0, 0};
    tbl[4] = '{0, 0, 0, 0,  0,  1, 1, 0, 0, 0, 3, 1};
    tbl[5] = '{0, 0, 0, 0,  0,  1, 1, 0, 0, 0, 3, 1};
    tbl[6] = '{0, 0, 0, 0,  0,  1, 1, 0, 0, 0, 3, 1};
    tbl[7] = '{0, 0, 0, 0,  0,  1, 1, 1, 1, 2, 3, 1};
    tbl[8] = '{0, 0, 0, 0,  1,  1, 0, 0, 0, 0, 3, 1};

    idle_in();
    bus.i_cmd_idx = 0; bus.i_cmd_wtf = 0; bus.i_cmd_timeout = 0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    tick(2);
    chk_reset_vals("rst");
    rst_n = 1'b1;
    chk_en = 1'b1;

    for (int i = 0; i < 9; i++) begin
      bus.i_cmd_valid = tbl[i].v; bus.i_cmd_idx = tbl[i].idx;
      bus.i_cmd_wtf = tbl[i].wtf; bus.i_cmd_timeout = tbl[i].to;
      bus.i_rsp_ready = tbl[i].rr;
      tick(1);
      chk($sformatf("t%0d_ready", i), bus.o_cmd_ready, tbl[i].e_rdy);
      chk($sformatf("t%0d_busy", i), bus.o_busy, tbl[i].e_busy);
      chk($sformatf("t%0d_rsp_valid", i), bus.o_rsp_valid, tbl[i].e_rv);
      chk($sformatf("t%0d_wait_en", i), bus.o_wait_en, tbl[i].e_en);
      chk($sformatf("t%0d_sel", i), bus.o_sel_wtr_wtf, tbl[i].e_sel);
      if (tbl[i].e_rv) begin
        chk($sformatf("t%0d_status", i), bus.o_rsp_status, tbl[i].e_st);
        chk($sformatf("t%0d_cycles", i), bus.o_rsp_cycles, tbl[i].e_cy);
      end
    end
    idle_in();

    // DONE after 10 WAIT cycles; detector outputs loaded two edges after push
    set_cmd(2, 0, 100);
    tick(1); bus.i_cmd_valid = 0;
    chk("done_pre_load_en", bus.o_wait_en, 3);
    tick(1);
    chk("done_load_en", bus.o_wait_en, 2);
    chk("done_load_sel", bus.o_sel_wtr_wtf, 0);
    tick(11);
    chk("done_early_rv", bus.o_rsp_valid, 0);
    bus.i_wait_done = 1;
    tick(1); bus.i_wait_done = 0;
    chk("done_rv", bus.o_rsp_valid, 1);
    chk("done_st", bus.o_rsp_status, 0);
    chk("done_cy", bus.o_rsp_cycles, 11);
    chk("done_en", bus.o_wait_en, 2);
    ack();
    chk("done_ack_rv", bus.o_rsp_valid, 0);

    // TIMEOUT 8, response exactly at the 8th WAIT cycle
    set_cmd(1, 1, 8);
    tick(1); bus.i_cmd_valid = 0;
    tick(9);
    chk("to_early_rv", bus.o_rsp_valid, 0);
    tick(1);
    chk("to_rv", bus.o_rsp_valid, 1);
    chk("to_st", bus.o_rsp_status, 1);
    chk("to_cy", bus.o_rsp_cycles, 8);
    chk("to_sel", bus.o_sel_wtr_wtf, 1);
    ack();

    // timeout 0 never expires; abort reports the running count
    set_cmd(4, 0, 0);
    tick(1); bus.i_cmd_valid = 0;
    tick(1000);
    chk("to0_rv", bus.o_rsp_valid, 0);
    chk("to0_busy", bus.o_busy, 1);
    bus.i_abort = 1;
    tick(1); bus.i_abort = 0;
    chk("to0_ab_st", bus.o_rsp_status, 3);
    chk("to0_ab_cy", bus.o_rsp_cycles, 998);
    ack();

    // fill the queue while a response is held
    set_cmd(0, 0, 3);
    tick(1); bus.i_cmd_valid = 0;
    tick(5);
    chk("full_hold_rv", bus.o_rsp_valid, 1);
    for (int i = 0; i < 5; i++) begin
      set_cmd(i + 1, 0, i + 2);
      tick(1);
      chk($sformatf("full_ready%0d", i), bus.o_cmd_ready, i < 3);
    end
    bus.i_cmd_valid = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      chk("hold_rv", bus.o_rsp_valid, 1);
      chk("hold_st", bus.o_rsp_status, 1);
      chk("hold_cy", bus.o_rsp_cycles, 3);
      chk("hold_en", bus.o_wait_en, 0);
    end
    ack();
    for (int i = 0; i < 4; i++) get_rsp($sformatf("fifo%0d", i), 1, i + 2);
    tick(20);
    chk("fifo_drop_rv", bus.o_rsp_valid, 0);
    chk("fifo_drop_busy", bus.o_busy, 0);

    // done ignored in ARM; done on the timeout cycle wins
    set_cmd(3, 0, 6);
    tick(1); bus.i_cmd_valid = 0;
    tick(1); bus.i_wait_done = 1;
    tick(1); bus.i_wait_done = 0;
    chk("arm_done_rv", bus.o_rsp_valid, 0);
    tick(5); bus.i_wait_done = 1;
    tick(1); bus.i_wait_done = 0;
    chk("tie_rv", bus.o_rsp_valid, 1);
    chk("tie_st", bus.o_rsp_status, 0);
    chk("tie_cy", bus.o_rsp_cycles, 6);
    ack();

    // abort at counter 3 with two commands queued
    set_cmd(1, 0, 0);
    tick(1); set_cmd(2, 0, 0);
    tick(1); set_cmd(3, 0, 0);
    tick(1); bus.i_cmd_valid = 0;
    tick(3); bus.i_abort = 1;
    tick(1); bus.i_abort = 0;
    chk("abort_rv", bus.o_rsp_valid, 1);
    chk("abort_st", bus.o_rsp_status, 3);
    chk("abort_cy", bus.o_rsp_cycles, 3);
    chk("abort_ready", bus.o_cmd_ready, 1);
    ack();
    chk("abort_busy", bus.o_busy, 0);
    tick(10);
    chk("abort_flushed_rv", bus.o_rsp_valid, 0);

    // asynchronous reset mid-WAIT
    set_cmd(2, 1, 0);
    tick(1); bus.i_cmd_valid = 0;
    tick(4);
    chk("prerst_busy", bus.o_busy, 1);
    chk_en = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("midrst");
    tick(1); rst_n = 1'b1;
    tick(1); chk_en = 1'b1;

    for (int i = 0; i < 3000; i++) begin
      int r;
      r = $urandom_range(0, 7);
      bus.i_cmd_valid   = $urandom_range(0, 99) < 40;
      bus.i_cmd_idx     = (r == 7) ? -1 : r;
      bus.i_cmd_wtf     = 1'($urandom_range(0, 1));
      bus.i_cmd_timeout = $urandom_range(0, 12);
      bus.i_abort       = $urandom_range(0, 99) < 2;
      bus.i_wait_done   = $urandom_range(0, 99) < 8;
      bus.i_rsp_ready   = $urandom_range(0, 99) < 50;
      tick(1);
    end
    idle_in();
    tick(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
